// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the tiny RISC-V core: walks each instruction
// through FETCH/DECODE/EXECUTE/MEM/WRITEBACK and halts on illegal encodings or memory timeouts.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  fault,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEM       = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] F_NONE    = 2'd0;
  localparam logic [1:0] F_ILLEGAL = 2'd1;
  localparam logic [1:0] F_DMEM_TO = 2'd2;
  localparam logic [1:0] F_IMEM_TO = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [1:0]  fault_q, fault_d;
  logic [31:0] instret_q;
  logic [31:0] wait_q, wait_d;

  logic is_op, is_opimm, is_lui, is_auipc, is_jal, is_jalr, is_load, is_store, is_branch;
  logic legal, tmo;

  assign is_op     = (opcode == OPC_OP);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  assign legal = is_op | is_opimm | is_lui | is_auipc | is_jal
               | (is_jalr   && (funct3 == 3'b000))
               | (is_load   && (funct3 == 3'b010))
               | (is_store  && (funct3 == 3'b010))
               | (is_branch && (funct3 != 3'b010) && (funct3 != 3'b011));

  // A ready arriving in the same cycle as the limit is checked first and wins.
  assign tmo = (TIMEOUT != 0) && (wait_q == TIMEOUT);

  always_comb begin
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    reg_write  = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 2'd0;
    alu_a_sel  = 1'b0;
    alu_b_sel  = 1'b0;
    wb_sel     = 2'd0;
    state_d    = state_q;
    fault_d    = fault_q;
    wait_d     = '0;

    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo) begin
          state_d = S_HALT;
          fault_d = F_IMEM_TO;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_HALT;
          fault_d = F_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if (is_branch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? 2'd1 : 2'd0;
          state_d  = S_FETCH;
        end else if (is_jal) begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          pc_write  = 1'b1;
          pc_sel    = 2'd1;
          state_d   = S_FETCH;
        end else if (is_jalr) begin
          alu_b_sel = 1'b1;
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          pc_write  = 1'b1;
          pc_sel    = 2'd2;
          state_d   = S_FETCH;
        end else if (is_load || is_store) begin
          alu_b_sel = 1'b1;
          state_d   = S_MEM;
        end else begin
          alu_a_sel = is_auipc;
          alu_b_sel = is_opimm | is_auipc;
          state_d   = S_WRITEBACK;
        end
      end
      S_MEM: begin
        alu_b_sel  = 1'b1;
        dmem_read  = is_load;
        dmem_write = is_store;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WRITEBACK;
          end else begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
        end else if (tmo) begin
          state_d = S_HALT;
          fault_d = F_DMEM_TO;
        end else begin
          wait_d = wait_q + 32'd1;
        end
      end
      S_WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = is_load ? 2'd1 : (is_lui ? 2'd3 : 2'd0);
        alu_a_sel = is_auipc;
        alu_b_sel = is_opimm | is_auipc | is_load;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_HALT;
        fault_d = F_ILLEGAL;
      end
    endcase

    if (reset) begin
      imem_req   = 1'b0;
      ir_write   = 1'b0;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      reg_write  = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = 2'd0;
      alu_a_sel  = 1'b0;
      alu_b_sel  = 1'b0;
      wb_sel     = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      fault_q   <= F_NONE;
      instret_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
      if (pc_write) instret_q <= instret_q + 32'd1;
    end
  end

  assign fault   = fault_q;
  assign instret = instret_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed scenarios plus randomized instructions checked
// against a per-instruction transaction model (latency, strobe counts, selects).
module tb_multicycle_control;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic        imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write;
  logic [1:0]  pc_sel, wb_sel, fault;
  logic        alu_a_sel, alu_b_sel;
  logic [31:0] instret;
  logic [2:0]  state;
  logic [5:0]  strobes;
  logic [5:0]  selects;

  int checks = 0;
  int errors = 0;
  int unsigned exp_instret = 0;

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_write(ir_write), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .reg_write(reg_write), .pc_write(pc_write), .pc_sel(pc_sel), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .fault(fault), .instret(instret), .state(state)
  );

  always #5 clk = ~clk;

  assign strobes = {imem_req, ir_write, dmem_read, dmem_write, reg_write, pc_write};
  assign selects = {pc_sel, alu_a_sel, alu_b_sel, wb_sel};

  typedef struct {
    bit          legal;
    bit          has_wb;
    int unsigned cycles;
    int unsigned pcw;
    int unsigned rw;
    int unsigned rd;
    int unsigned wr;
    logic [1:0]  pcsel;
    logic [1:0]  wbsel;
    logic        alua;
    logic        alub;
  } exp_t;

  // Transaction-level expectation for one instruction, taken from the latency table.
  function automatic exp_t model(input logic [6:0] o, input logic [2:0] f, input logic br,
                                 input int unsigned id, input int unsigned dd);
    exp_t m;
    m = '{default: '0};
    case (o)
      OP:     begin m.legal = 1; m.cycles = 4; m.rw = 1; m.has_wb = 1; end
      OPIMM:  begin m.legal = 1; m.cycles = 4; m.rw = 1; m.has_wb = 1; m.alub = 1; end
      LUI:    begin m.legal = 1; m.cycles = 4; m.rw = 1; m.has_wb = 1; m.wbsel = 3; end
      AUIPC:  begin m.legal = 1; m.cycles = 4; m.rw = 1; m.has_wb = 1; m.alua = 1; m.alub = 1; end
      JAL:    begin m.legal = 1; m.cycles = 3; m.rw = 1; m.wbsel = 2; m.pcsel = 1; end
      JALR:   begin m.legal = (f == 0); m.cycles = 3; m.rw = 1; m.wbsel = 2; m.pcsel = 2; m.alub = 1; end
      LOAD:   begin m.legal = (f == 2); m.cycles = 5 + dd; m.rw = 1; m.has_wb = 1; m.wbsel = 1;
                    m.alub = 1; m.rd = dd + 1; end
      STORE:  begin m.legal = (f == 2); m.cycles = 4 + dd; m.alub = 1; m.wr = dd + 1; end
      BRANCH: begin m.legal = (f != 2) && (f != 3); m.cycles = 3; m.pcsel = {1'b0, br}; end
      default: m.legal = 0;
    endcase
    if (m.legal) begin
      m.cycles = m.cycles + id;
      m.pcw    = 1;
    end else begin
      m = '{default: '0};
      m.cycles = id + 2;
    end
    return m;
  endfunction

  int unsigned r_cycles, r_pcw, r_rw, r_rd, r_wr, r_rw_cyc;
  logic [1:0]  r_pcsel, r_wbsel, r_fault;
  logic        r_alua, r_alub, r_wba, r_wbb, r_halted;
  logic [31:0] r_instret;
  logic [2:0]  r_endstate;
  int          r_states[$];

  // Drives one instruction from FETCH; stops after the pc_write cycle or on reaching HALT.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic br,
                           input int unsigned id, input int unsigned dd);
    int unsigned ireq = 0, dreq = 0;
    bit done = 0;
    r_cycles = 0; r_pcw = 0; r_rw = 0; r_rd = 0; r_wr = 0; r_rw_cyc = 0;
    r_pcsel = 0; r_wbsel = 0; r_fault = 0; r_alua = 0; r_alub = 0;
    r_wba = 0; r_wbb = 0; r_halted = 0; r_instret = 0; r_endstate = 0;
    r_states.delete();
    opcode = o; funct3 = f; branch_taken = br;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk); #1;
      if (state == 3'd5) begin
        r_halted = 1; r_fault = fault; done = 1;
      end else begin
        imem_ready = imem_req && (ireq >= id);
        dmem_ready = (dmem_read || dmem_write) && (dreq >= dd);
        #1;
        r_cycles++;
        r_states.push_back(int'(state));
        if (imem_req) ireq++;
        if (dmem_read || dmem_write) dreq++;
        if (dmem_read) r_rd++;
        if (dmem_write) r_wr++;
        if (state == 3'd2) begin r_alua = alu_a_sel; r_alub = alu_b_sel; end
        if (state == 3'd4) begin r_wba = alu_a_sel; r_wbb = alu_b_sel; end
        if (reg_write) begin r_rw++; r_wbsel = wb_sel; r_rw_cyc = r_cycles; end
        if (pc_write) begin r_pcw++; r_pcsel = pc_sel; done = 1; end
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL instr_bound opcode=%b: no completion or halt within 80 cycles", o);
    end
    if (r_pcw != 0) begin
      @(posedge clk); #1;
      r_instret = instret; r_endstate = state;
    end
    imem_ready = 0; dmem_ready = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1; imem_ready = 0; dmem_ready = 0;
    @(posedge clk); #1;
    reset = 0;
    exp_instret = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; imem_ready = 1; dmem_ready = 1; opcode = OP; branch_taken = 1;
    #1;
    checks++;
    if (strobes !== 6'b0 || selects !== 6'b0) begin
      errors++; $display("FAIL reset_outputs strobes=%b selects=%b expected 0/0", strobes, selects);
    end
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || fault !== 2'd0 || instret !== 32'd0) begin
      errors++; $display("FAIL reset_state state=%0d fault=%0d instret=%0d expected 0/0/0", state, fault, instret);
    end
    checks++;
    if (strobes !== 6'b0) begin
      errors++; $display("FAIL reset_held strobes=%b expected 0", strobes);
    end
    reset = 0; #1;
    checks++;
    if (imem_req !== 1'b1 || ir_write !== 1'b1) begin
      errors++; $display("FAIL reset_release imem_req=%b ir_write=%b expected 1/1", imem_req, ir_write);
    end
    imem_ready = 0; dmem_ready = 0; branch_taken = 0;
    exp_instret = 0;
  endtask

  task automatic test_add();
    int exp_seq[4] = '{0, 1, 2, 4};
    bit bad = 0;
    run_instr(OP, 3'b000, 0, 0, 0);
    exp_instret++;
    if (r_states.size() != 4) bad = 1;
    else for (int i = 0; i < 4; i++) if (r_states[i] != exp_seq[i]) bad = 1;
    checks++;
    if (bad) begin errors++; $display("FAIL add_states got %p expected 0,1,2,4", r_states); end
    checks++;
    if (r_rw != 1 || r_rw_cyc != 4 || r_pcw != 1 || r_cycles != 4) begin
      errors++; $display("FAIL add_strobes rw=%0d rw_cyc=%0d pcw=%0d cycles=%0d expected 1/4/1/4",
                         r_rw, r_rw_cyc, r_pcw, r_cycles);
    end
    checks++;
    if (r_instret !== exp_instret || r_endstate !== 3'd0) begin
      errors++; $display("FAIL add_instret instret=%0d state=%0d expected %0d/0", r_instret, r_endstate, exp_instret);
    end
  endtask

  task automatic test_load_delay();
    run_instr(LOAD, 3'b010, 0, 0, 3);
    exp_instret++;
    checks++;
    if (r_rd != 4 || r_cycles != 8 || r_wbsel !== 2'd1 || r_rw != 1) begin
      errors++; $display("FAIL lw_delay rd=%0d cycles=%0d wbsel=%0d rw=%0d expected 4/8/1/1",
                         r_rd, r_cycles, r_wbsel, r_rw);
    end
    checks++;
    if (r_instret !== exp_instret) begin
      errors++; $display("FAIL lw_instret instret=%0d expected %0d", r_instret, exp_instret);
    end
  endtask

  task automatic test_branch();
    for (int t = 1; t >= 0; t--) begin
      run_instr(BRANCH, 3'b000, t[0], 0, 0);
      exp_instret++;
      checks++;
      if (r_pcsel !== {1'b0, t[0]} || r_pcw != 1 || r_rw != 0 || r_cycles != 3) begin
        errors++; $display("FAIL beq_taken%0d pcsel=%0d pcw=%0d rw=%0d cycles=%0d expected %0d/1/0/3",
                           t, r_pcsel, r_pcw, r_rw, r_cycles, t);
      end
      checks++;
      if (r_instret !== exp_instret) begin
        errors++; $display("FAIL beq_instret instret=%0d expected %0d", r_instret, exp_instret);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] o;
    logic [2:0] f;
    exp_t m;
    int bad;
    for (int n = 0; n < 5; n++) begin
      if (n == 0) begin o = 7'b1111111; f = 3'b000; end
      else if (n == 1) begin o = LOAD; f = 3'b000; end
      else begin
        do begin o = 7'($urandom); f = 3'($urandom); m = model(o, f, 0, 0, 0); end while (m.legal);
      end
      apply_reset();
      m = model(o, f, 0, 1, 0);
      run_instr(o, f, 0, 1, 0);
      checks++;
      if (!r_halted || r_fault !== 2'd1 || r_cycles != m.cycles) begin
        errors++; $display("FAIL illegal_%b_%b halted=%b fault=%0d cycles=%0d expected 1/1/%0d",
                           o, f, r_halted, r_fault, r_cycles, m.cycles);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        imem_ready = 1'($urandom); dmem_ready = 1'($urandom); branch_taken = 1'($urandom);
        #1;
        if (state !== 3'd5 || fault !== 2'd1 || strobes !== 6'b0 || instret !== 32'd0) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL illegal_hold bad_cycles=%0d expected 0", bad); end
      apply_reset();
      checks++;
      if (state !== 3'd0 || fault !== 2'd0) begin
        errors++; $display("FAIL illegal_reset state=%0d fault=%0d expected 0/0", state, fault);
      end
    end
  endtask

  task automatic test_timeout();
    int halt_k = -1;
    apply_reset();
    for (int k = 0; k < 40 && halt_k < 0; k++) begin
      @(negedge clk); imem_ready = 0; #1;
      if (state == 3'd5) halt_k = k;
    end
    checks++;
    if (halt_k != 16 || fault !== 2'd3) begin
      errors++; $display("FAIL imem_timeout halt_cycle=%0d fault=%0d expected 16/3", halt_k, fault);
    end
    apply_reset();
    opcode = OP; funct3 = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); imem_ready = (k == 15); #1;
      if (k == 15) begin
        checks++;
        if (ir_write !== 1'b1 || fault !== 2'd0 || state !== 3'd0) begin
          errors++; $display("FAIL imem_ready_at_limit ir_write=%b fault=%0d state=%0d expected 1/0/0",
                             ir_write, fault, state);
        end
      end
    end
    @(posedge clk); #1;
    imem_ready = 0;
    checks++;
    if (state !== 3'd1 || fault !== 2'd0) begin
      errors++; $display("FAIL imem_limit_decode state=%0d fault=%0d expected 1/0", state, fault);
    end
    apply_reset();
    run_instr(STORE, 3'b010, 0, 0, 16);
    checks++;
    if (!r_halted || r_fault !== 2'd2 || r_wr != 16 || r_pcw != 0) begin
      errors++; $display("FAIL dmem_timeout halted=%b fault=%0d wr=%0d pcw=%0d expected 1/2/16/0",
                         r_halted, r_fault, r_wr, r_pcw);
    end
    apply_reset();
    run_instr(STORE, 3'b010, 0, 0, 15);
    exp_instret++;
    checks++;
    if (r_halted || r_pcw != 1 || r_wr != 16 || r_cycles != 19 || r_instret !== exp_instret) begin
      errors++; $display("FAIL dmem_ready_at_limit halted=%b pcw=%0d wr=%0d cycles=%0d instret=%0d expected 0/1/16/19/%0d",
                         r_halted, r_pcw, r_wr, r_cycles, r_instret, exp_instret);
    end
  endtask

  task automatic test_reset_in_mem();
    apply_reset();
    opcode = STORE; funct3 = 3'b010; dmem_ready = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); imem_ready = (c == 0); #1;
    end
    checks++;
    if (state !== 3'd3 || dmem_write !== 1'b1) begin
      errors++; $display("FAIL store_in_mem state=%0d dmem_write=%b expected 3/1", state, dmem_write);
    end
    @(negedge clk); reset = 1; #1;
    checks++;
    if (dmem_write !== 1'b0 || pc_write !== 1'b0) begin
      errors++; $display("FAIL mem_reset_strobes dmem_write=%b pc_write=%b expected 0/0", dmem_write, pc_write);
    end
    @(posedge clk); #1;
    reset = 0; #1;
    exp_instret = 0;
    checks++;
    if (state !== 3'd0 || imem_req !== 1'b1 || instret !== 32'd0) begin
      errors++; $display("FAIL mem_reset_resume state=%0d imem_req=%b instret=%0d expected 0/1/0",
                         state, imem_req, instret);
    end
  endtask

  task automatic test_random();
    logic [6:0] classes[9] = '{OP, OPIMM, LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH};
    logic [2:0] bf[6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [6:0] o;
    logic [2:0] f;
    logic br;
    int unsigned id, dd;
    exp_t m;
    apply_reset();
    for (int n = 0; n < 40; n++) begin
      o  = classes[$urandom_range(0, 8)];
      f  = 3'($urandom);
      if (o == JALR) f = 3'd0;
      if (o == LOAD || o == STORE) f = 3'd2;
      if (o == BRANCH) f = bf[$urandom_range(0, 5)];
      br = 1'($urandom);
      id = $urandom_range(0, 3);
      dd = $urandom_range(0, 4);
      m  = model(o, f, br, id, dd);
      run_instr(o, f, br, id, dd);
      exp_instret++;
      checks++;
      if (r_cycles != m.cycles || r_pcw != m.pcw || r_rw != m.rw || r_rd != m.rd || r_wr != m.wr) begin
        errors++; $display("FAIL rand%0d_%b_counts cyc=%0d pcw=%0d rw=%0d rd=%0d wr=%0d expected %0d/%0d/%0d/%0d/%0d",
                           n, o, r_cycles, r_pcw, r_rw, r_rd, r_wr, m.cycles, m.pcw, m.rw, m.rd, m.wr);
      end
      checks++;
      if (r_pcsel !== m.pcsel || (m.rw != 0 && r_wbsel !== m.wbsel) ||
          r_alua !== m.alua || r_alub !== m.alub ||
          (m.has_wb && (r_wba !== m.alua || r_wbb !== m.alub))) begin
        errors++; $display("FAIL rand%0d_%b_selects pcsel=%0d wbsel=%0d alu=%b%b wbalu=%b%b expected %0d/%0d/%b%b",
                           n, o, r_pcsel, r_wbsel, r_alua, r_alub, r_wba, r_wbb, m.pcsel, m.wbsel, m.alua, m.alub);
      end
      checks++;
      if (r_instret !== exp_instret || r_endstate !== 3'd0) begin
        errors++; $display("FAIL rand%0d_instret instret=%0d state=%0d expected %0d/0", n, r_instret, r_endstate, exp_instret);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_delay();
    test_branch();
    test_illegal();
    test_timeout();
    test_reset_in_mem();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM for the tiny RISC-V core.
- Sequences each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK.
- Drives strobes and mux selects for the IR, PC, register file, ALU and data memory, using the opcode/funct3 fields the instruction parser extracts from the IR.
- Detects illegal encodings and memory timeouts; on either it halts until reset.

Parameters:
- TIMEOUT, 15: max cycles waiting for imem_ready/dmem_ready before fault; 0 disables timeout.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0] from instruction parser
- funct3  in  3  IR[14:12] from instruction parser
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- branch_taken  in  1  ALU compare result for current branch
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load IR from imem
- dmem_read  out  1  load request
- dmem_write  out  1  store request
- reg_write  out  1  register file write enable
- pc_write  out  1  PC update enable
- pc_sel  out  2  0: pc+4, 1: pc+imm, 2: ALU result (JALR)
- alu_a_sel  out  1  0: rs1, 1: pc
- alu_b_sel  out  1  0: rs2, 1: imm
- wb_sel  out  2  0: ALU, 1: mem data, 2: pc+4, 3: imm (LUI)
- fault  out  2  0: none, 1: illegal instr, 2: dmem timeout, 3: imem timeout
- instret  out  32  retired instruction count
- state  out  3  current FSM state, for debug

Behaviour:
- Reset:
  - State goes to FETCH; fault=0, instret=0, wait counter=0.
  - While reset is high, all strobes are forced to 0 and all selects to 0.
  - Reset mid-instruction abandons it with no pc_write or reg_write.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, HALT=5.
- Outputs are decoded combinationally from state and opcode/funct3. Strobes not listed below are 0.
- FETCH:
  - imem_req=1.
  - When imem_ready=1, ir_write=1 in the same cycle and next state is DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE:
  - Legal classes:
    - OP 0110011
    - OP-IMM 0010011
    - LUI 0110111
    - AUIPC 0010111
    - JAL 1101111
    - JALR 1100111 with funct3=000
    - LOAD 0000011 with funct3=010 (LW only)
    - STORE 0100011 with funct3=010
    - BRANCH 1100011 with funct3 not 010 and not 011
  - Legal class: go to EXECUTE. Anything else: fault=1, go to HALT.
- EXECUTE:
  - OP: alu_a=0, alu_b=0; go to WRITEBACK.
  - OP-IMM, LOAD, STORE: alu_b=1. OP-IMM goes to WRITEBACK; LOAD and STORE go to MEM.
  - AUIPC: alu_a=1, alu_b=1; go to WRITEBACK.
  - LUI: go to WRITEBACK.
  - BRANCH: alu_a=0, alu_b=0, pc_write=1, pc_sel = branch_taken ? 1 : 0; go to FETCH.
  - JAL: reg_write=1, wb_sel=2, pc_write=1, pc_sel=1; go to FETCH.
  - JALR: alu_b=1, reg_write=1, wb_sel=2, pc_write=1, pc_sel=2; go to FETCH.
- MEM:
  - alu_b=1 is held throughout.
  - dmem_read (LOAD) or dmem_write (STORE) is held until dmem_ready=1.
  - On ready: LOAD goes to WRITEBACK; STORE asserts pc_write=1, pc_sel=0 and goes to FETCH.
- WRITEBACK:
  - reg_write=1, pc_write=1, pc_sel=0; go to FETCH.
  - wb_sel: 1 for LOAD, 3 for LUI, 0 otherwise.
  - ALU selects keep their EXECUTE values.
- HALT:
  - All strobes are 0 and fault is held.
  - Left only by reset.
- Timeout:
  - The wait counter clears on every state transition.
  - In FETCH or MEM, if the counter equals TIMEOUT (TIMEOUT>0) and ready is still low, go to HALT with fault=3 (FETCH) or 2 (MEM).
  - Ready arriving in the same cycle wins over the timeout.
- instret:
  - Increments by 1 on each cycle with pc_write=1, wrapping at 2^32.
  - Never increments on a fault.
- Latency with ready inputs tied high:
  - BRANCH, JAL, JALR: 3 cycles.
  - OP, OP-IMM, LUI, AUIPC, STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each ready wait cycle adds 1.
- Inputs are sampled only in the states listed; opcode and funct3 must be stable from DECODE until the instruction returns to FETCH.

Test Plan:
- Reset, then ADD (opcode 0110011) with ready tied high → state sequence 0,1,2,4,0; reg_write and pc_write high in cycle 4 only; instret=1.
- LW (0000011, funct3=010), dmem_ready delayed 3 cycles → dmem_read held for 4 cycles; then WRITEBACK with wb_sel=1; total 8 cycles; instret increments once.
- BEQ with branch_taken=1, then with branch_taken=0 → pc_sel=1 then 0 in EXECUTE; pc_write pulses once each; no reg_write.
- Opcode 1111111, then separately LOAD with funct3=000 → fault=1, state=5, all strobes 0 for 20 cycles; reset returns state to 0 and fault to 0.
- TIMEOUT=15, imem_ready held low → HALT with fault=3 exactly when the wait counter reaches 15; with ready rising in that same cycle → ir_write=1 and no fault.
- Reset asserted in MEM during a store → dmem_write drops in the reset cycle; no pc_write; instret unchanged at 0; FETCH resumes the cycle after reset deasserts.
